// File: rtl/ram_pkg.sv
// ram_pkg: shared encodings for the multi-channel RAM arbiter.
// Size codes, FSM states, RAM address width default and size helpers.
package ram_pkg;

    localparam int RAM_AW_DEF = 17;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } arb_state_t;

    // Index of the final byte of an access; 2'b11 also counts as word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        if (size == SIZE_B)
            return 2'd0;
        else if (size == SIZE_H)
            return 2'd1;
        else
            return 2'd3;
    endfunction

    // Keeps only the bytes an access of this size actually read.
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        if (size == SIZE_B)
            return 32'h0000_00FF;
        else if (size == SIZE_H)
            return 32'h0000_FFFF;
        else
            return 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational channel pick from requests and last grant.
// RAM_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_grant;

    // Scan from the top so the lowest requesting index is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] c;

    // Search starts one past the last grant and wraps around.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        c         = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = IDX_W'((int'(last_grant) + i) % NUM_CH);
            if (!gnt_valid && req[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = c;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter_mc.sv
// ram_arbiter_mc: grants one requester at a time onto the byte-wide RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_arbiter_mc
    import ram_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 32,
    parameter int RAM_ADDR_WIDTH = RAM_AW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [NUM_CH-1:0]         we_i,
    input  logic [2*NUM_CH-1:0]       size_i,
    input  logic [ADDR_W*NUM_CH-1:0]  addr_i,
    input  logic [32*NUM_CH-1:0]      wdata_i,
    output logic [31:0]               rdata_o,
    output logic [NUM_CH-1:0]         done_o,
    output logic                      busy_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a_o,
    output logic                      ram_wr_o,
    output logic [7:0]                ram_dout_o,
    input  logic [7:0]                ram_din_i
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] prev_idx;

    logic [IDX_W-1:0] gnt_q, last_q, arb_idx;
    logic             arb_valid;

    logic                      we_q;
    logic [1:0]                size_q;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q, rdata_q;

    assign prev_idx = cnt_q - 2'd1;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req        (req_i),
        .last_grant (last_q),
        .gnt_valid  (arb_valid),
        .gnt_idx    (arb_idx)
    );

    // State and byte counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one XFER cycle per byte, reads add a DRAIN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (cnt_q == last_idx(size_q))
                    state_d = we_q ? ST_DONE : ST_DRAIN;
                else
                    cnt_d = cnt_q + 2'd1;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's request in IDLE; collect read bytes one behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            we_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && arb_valid) begin
                gnt_q   <= arb_idx;
                last_q  <= arb_idx;
                we_q    <= we_i[arb_idx];
                size_q  <= size_i[{arb_idx, 1'b0} +: 2];
                addr_q  <= addr_i[int'(arb_idx)*ADDR_W +: RAM_ADDR_WIDTH];
                wdata_q <= wdata_i[int'(arb_idx)*32 +: 32];
                rdata_q <= '0;
            end
            if (state_q == ST_XFER && !we_q && cnt_q != 2'd0)
                rdata_q[{prev_idx, 3'b000} +: 8] <= ram_din_i;
            if (state_q == ST_DRAIN)
                rdata_q[{cnt_q, 3'b000} +: 8] <= ram_din_i;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ram_a_o    = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = '0;
        done_o     = '0;
        rdata_o    = '0;
        busy_o     = (state_q != ST_IDLE);
        if (state_q == ST_XFER) begin
            ram_a_o  = addr_q + RAM_ADDR_WIDTH'(cnt_q);
            ram_wr_o = we_q;
            if (we_q)
                ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
        end
        if (state_q == ST_DONE) begin
            done_o[gnt_q] = 1'b1;
            rdata_o       = rdata_q & size_mask(size_q);
        end
    end

endmodule

// File: doc/ram_arbiter_mc.md
# ram_arbiter_mc

Parametrised multi-channel arbiter between CPU memory requesters (IF, MEM, and later others) and the byte-wide single-port RAM (128 KiB, 17-bit address, one-cycle read latency). It grants one channel at a time, round-robin by default, and serialises 1/2/4-byte accesses into consecutive byte cycles. Each granted access ends with a one-cycle `done_o` pulse to the requester. It sits between the pipeline stages and `ram`.

## Interface
Parameters:
- `NUM_CH`, 2: number of requesting channels (1..8).
- `ADDR_W`, 32: requester address width.
- `RAM_ADDR_WIDTH`, 17: RAM address width.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_i` in NUM_CH: per-channel request. Held high until `done_o`.
- `we_i` in NUM_CH: 1 = write, 0 = read.
- `size_i` in 2*NUM_CH: 00 byte, 01 half, 1x word.
- `addr_i` in ADDR_W*NUM_CH: byte address, flattened with channel c at `[c*ADDR_W +: ADDR_W]`.
- `wdata_i` in 32*NUM_CH: store data, little-endian.
- `rdata_o` out 32: shared read data. Valid only while some `done_o` bit is 1.
- `done_o` out NUM_CH: one-cycle completion pulse, on the granted channel only.
- `busy_o` out 1: state is not IDLE.
- `ram_a_o` out RAM_ADDR_WIDTH: RAM address.
- `ram_wr_o` out 1: 1 = write (RAM `r_nw` = ~`ram_wr_o`).
- `ram_dout_o` out 8: byte to RAM.
- `ram_din_i` in 8: byte from RAM. Appears the cycle after its address.

## Operation
- FSM states: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If any `req_i` is high, pick a grant and latch channel index, we, address, size and wdata.
  - Set byte counter to 0 and go to XFER.
- XFER, one cycle per byte i = 0..N-1 (N = 1, 2 or 4):
  - `ram_a_o` = latched addr[RAM_ADDR_WIDTH-1:0] + i, modulo 2^RAM_ADDR_WIDTH (wraps at 0x1FFFF → 0x00000).
  - Writes: `ram_wr_o` = 1 and `ram_dout_o` = wdata byte i. After the last byte go to DONE.
  - Reads: `ram_wr_o` = 0. Byte i-1 is captured from `ram_din_i` at the end of cycle i. After the last byte go to DRAIN.
- DRAIN (reads only): capture byte N-1, then go to DONE.
- DONE:
  - `done_o[grant]` = 1; `rdata_o` = the assembled bytes, with bytes ≥ N forced to 0 (zero-extended; sign extension belongs to MEM).
  - No arbitration in DONE; next state is IDLE.
- Round-robin: the search starts at (last_grant+1) mod NUM_CH. `last_grant` updates on each grant and resets to NUM_CH-1, so channel 0 wins first after reset.
- Inputs are sampled only in IDLE. Changes to a granted channel's inputs mid-transfer are ignored.
- `req_i` dropping mid-transfer does not abort the access; it still completes and pulses `done_o`.
- Alignment is not checked.

## Timing
- Reset (async, `rst` low):
  - state IDLE, `done_o` 0, `rdata_o` 0, `busy_o` 0, `ram_wr_o` 0, `ram_a_o` 0, `ram_dout_o` 0, last_grant NUM_CH-1.
  - Asserting reset mid-transfer aborts immediately: `ram_wr_o` drops in the same instant and no `done_o` is produced.
- Latency is counted from the IDLE cycle in which `req_i` is seen (cycle 0):
  - read word: XFER 1–4, DRAIN 5, `done_o` in cycle 6;
  - read half: `done_o` in cycle 4;
  - read byte: `done_o` in cycle 3;
  - write word: XFER 1–4, `done_o` in cycle 5;
  - write byte: `done_o` in cycle 2.
- Back-to-back: the earliest next grant is the IDLE cycle right after DONE.
- A requester that keeps `req_i` high after `done_o` issues a new request.
- All outputs are registered or decoded from registered state and counter only. There is no combinational path from `req_i` to the RAM outputs.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and `last_grant` is unused. Channel 0 (MEM) is never starved; higher channels may starve.
  - Undefined (default): round-robin as above.

## Structure
- Shared package `ram_pkg` holds:
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`;
  - FSM state encodings;
  - `RAM_ADDR_WIDTH` default.
- Sub-module `rr_arbiter`: combinational grant from `req` and `last_grant`, parametrised by NUM_CH, with the fixed-priority variant under the macro.
- Byte counter, latch registers and FSM live in `ram_arbiter_mc`.

## Test plan
- Reset, single-channel word write/read:
  - Write word 0x0FF00FF0 to 0x100: RAM bytes 0x100..0x103 = F0 0F F0 0F; `done_o[0]` in cycle 5.
  - Read word from 0x100: `rdata_o` = 0x0FF00FF0 in cycle 6.
- Sized reads over word 0x0FF00FF0 at 0x100:
  - byte read of 0x101 → 0x0000000F (cycle 3);
  - half read of 0x102 → 0x00000FF0 (cycle 4).
- Contention, NUM_CH=2, both channels requesting word reads continuously: grants alternate 0,1,0,1, and each `done_o` pulse is 7 cycles apart. With `RAM_ARB_FIXED_PRIO_EN` defined, only channel 0 completes.
- Wrap-around: word write at 0x1FFFE → bytes land at 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset mid-write: assert `rst` low during XFER byte 1 → `ram_wr_o` = 0 immediately, no `done_o`, bytes 2–3 unchanged. After release, channel 0 is granted first.
- `req_i` dropped mid-read: the transfer completes and `done_o` still pulses once.
